// File: rtl/param_data_memory.sv
// rtl/param_data_memory.sv - word-addressed RAM with post-reset clear sweep and fixed-latency responses
// Optional error counter output guarded by DMEM_ERR_COUNT_EN.
module param_data_memory #(
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 24,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              pipe_valid [RD_LATENCY];
    logic              pipe_we    [RD_LATENCY];
    logic              pipe_err   [RD_LATENCY];
    logic [DATA_W-1:0] pipe_rdata [RD_LATENCY];

    logic             accept;
    logic             addr_err;
    logic [IDX_W-1:0] idx;

    // Compare one bit wider so DEPTH == 2**ADDR_W does not wrap to zero.
    assign addr_err  = ({1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH));
    assign idx       = req_addr[IDX_W-1:0];
    assign req_ready = (state == RUN);
    assign init_done = (state == RUN);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == IDX_W'(DEPTH - 1))
                state <= RUN;
        end
    end

    // Reset has priority: nothing is written on a reset edge, the sweep clears afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT)
                mem[cnt] <= '0;
            else if (accept && req_we && !addr_err)
                mem[idx] <= req_wdata;
        end
    end

    // Payload is forced to zero whenever a stage is empty, so idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_valid[k] <= 1'b0;
                pipe_we[k]    <= 1'b0;
                pipe_err[k]   <= 1'b0;
                pipe_rdata[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_we[0]    <= accept && req_we;
            pipe_err[0]   <= accept && addr_err;
            pipe_rdata[0] <= (accept && !req_we && !addr_err) ? mem[idx] : '0;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_we[k]    <= pipe_we[k-1];
                pipe_err[k]   <= pipe_err[k-1];
                pipe_rdata[k] <= pipe_rdata[k-1];
            end
        end
    end

    assign rsp_valid = pipe_valid[RD_LATENCY-1];
    assign rsp_we    = pipe_we[RD_LATENCY-1];
    assign rsp_err   = pipe_err[RD_LATENCY-1];
    assign rsp_rdata = pipe_rdata[RD_LATENCY-1];

`ifdef DMEM_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_count <= '0;
        else if (accept && addr_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_param_data_memory.sv
// tb/tb_param_data_memory.sv - bench for param_data_memory against a queue-based reference model
module tb_param_data_memory;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 24;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              init_done;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
`ifdef DMEM_ERR_COUNT_EN
    logic [7:0]        err_count;
`endif

    param_data_memory #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic              we;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    rsp_t              exp_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                cyc;
    int                init_edges;
    int                err_cnt;
    int                total;
    int                bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_q.delete();
        init_edges = 0;
        err_cnt    = 0;
    endtask

    // One clock: drive, update the model for an accepted request, then check after the edge.
    task automatic cycle(input logic rst, input logic v, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rsp_t r;
        logic ev;
        logic ready_now;
        ready_now = (init_edges >= DEPTH);
        reset     = rst;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        if (v && ready_now && !rst) begin
            r.due   = cyc + LAT;
            r.we    = we;
            r.err   = (int'(a) >= DEPTH);
            r.rdata = (!we && !r.err) ? model_mem[int'(a)] : '0;
            exp_q.push_back(r);
            if (we && !r.err) model_mem[int'(a)] = d;
            if (r.err && err_cnt < 255) err_cnt++;
        end
        @(posedge clk);
        cyc++;
        if (rst) model_clear();
        else if (init_edges < DEPTH) init_edges++;
        #1;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r  = exp_q.pop_front();
            ev = 1'b1;
        end else begin
            r.we = 1'b0; r.rdata = '0; r.err = 1'b0;
            ev = 1'b0;
        end
        chk("req_ready", req_ready, init_edges >= DEPTH);
        chk("init_done", init_done, init_edges >= DEPTH);
        chk("rsp_valid", rsp_valid, ev);
        chk("rsp_we",    rsp_we,    r.we);
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp_err",   rsp_err,   r.err);
`ifdef DMEM_ERR_COUNT_EN
        chk("err_count", err_count, err_cnt);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        cycle(1'b0, 1'b1, 1'b0, a, '0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cycle(1'b0, 1'b1, 1'b1, a, d);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        total = 0; bad = 0; cyc = 0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        @(posedge clk);
        #1;
        model_clear();

        // Reset held two cycles, then INIT with a write pending the whole sweep.
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH + 1; i++) wr(12'd2, 12'h123);
        idle(LAT);

        for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i));
        idle(LAT);

        // Read-after-write back to back.
        wr(12'd5, 12'hABC);
        rd(12'd5);
        idle(LAT);

        // Fill then pipelined reads.
        for (int i = 0; i < DEPTH; i++) wr(ADDR_W'(i), DATA_W'(i + 1));
        for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i));
        idle(LAT);

        // Out-of-range accesses, boundary DEPTH-1, and memory unchanged.
        wr(12'd24, 12'h777);
        rd(12'd24);
        rd(12'hFFF);
        rd(12'd23);
        for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i));
        idle(LAT);

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) ra = 12'hFFF - ADDR_W'($urandom_range(0, 3));
            else ra = ADDR_W'($urandom_range(0, DEPTH + 3));
            cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, DATA_W'($urandom));
        end
        idle(LAT);

        // Reset mid-stream with a write presented on the reset edge.
        wr(12'd7, 12'h5A5);
        rd(12'd7);
        rd(12'd8);
        rd(12'd9);
        cycle(1'b1, 1'b1, 1'b1, 12'd9, 12'hFFF);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i));
        idle(LAT + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
